// File: rtl/ks_pkg.sv
// Shared Kogge-Stone definitions for the adder and subtractor datapaths.
// Holds the prefix-depth function, the P/G bundle type and the mid-register tap level.
package ks_pkg;

    localparam int KS_WIDTH = 16;

    function automatic int ks_levels(input int width);
        return $clog2(width);
    endfunction

    localparam int LEVELS    = ks_levels(KS_WIDTH);
    localparam int MID_LEVEL = LEVELS / 2;

    typedef struct packed {
        logic [KS_WIDTH-1:0] p;
        logic [KS_WIDTH-1:0] g;
    } pg_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: every bit at or above DIST merges
// with the group DIST positions below it; the lower bits pass through unchanged.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] g_i,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] g_o
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi >= DIST) begin : g_merge
                assign g_o[gi] = g_i[gi] | (p_i[gi] & g_i[gi-DIST]);
                assign p_o[gi] = p_i[gi] & p_i[gi-DIST];
            end else begin : g_pass
                assign g_o[gi] = g_i[gi];
                assign p_o[gi] = p_i[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/ks_pipe_sub.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin computed as a + ~b + ~bin.
// Optional registered ovf/zero/neg flags are enabled by defining KS_SUB_FLAGS_EN.
module ks_pipe_sub
    import ks_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MID_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef KS_SUB_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int LV  = ks_levels(WIDTH);
    localparam int MID = LV / 2;

    logic             s0_valid_q;
    logic [WIDTH-1:0] s0_p_q;
    logic [WIDTH-1:0] s0_g_q;
    logic             s0_cin_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             adv_out;
    logic             adv_fin;
    logic             adv_s0;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_p0;
    logic             fin_cin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d;
    logic [WIDTH-1:0] lv_p   [LV+1];
    logic [WIDTH-1:0] lv_g   [LV+1];
    logic [WIDTH-1:0] lvin_p [LV];
    logic [WIDTH-1:0] lvin_g [LV];
`ifdef KS_SUB_FLAGS_EN
    logic             s0_amsb_q;
    logic             s0_bmsb_q;
    logic             fin_amsb;
    logic             fin_bmsb;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;
`endif

    assign adv_out  = ~out_valid_q | out_ready;
    assign adv_s0   = ~s0_valid_q | adv_fin;
    assign in_ready = adv_s0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_p_q     <= '0;
            s0_g_q     <= '0;
            s0_cin_q   <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
            s0_amsb_q  <= 1'b0;
            s0_bmsb_q  <= 1'b0;
`endif
        end else if (adv_s0) begin
            s0_valid_q <= in_valid;
            if (in_valid) begin
                s0_p_q   <= a ^ ~b;
                s0_g_q   <= a & ~b;
                s0_cin_q <= ~bin;
`ifdef KS_SUB_FLAGS_EN
                s0_amsb_q <= a[WIDTH-1];
                s0_bmsb_q <= b[WIDTH-1];
`endif
            end
        end
    end

    // Carry-in acts as the generate of bit -1, so fold it into bit 0 before the tree.
    assign lv_p[0] = s0_p_q;
    assign lv_g[0] = {s0_g_q[WIDTH-1:1], s0_g_q[0] | (s0_p_q[0] & s0_cin_q)};

    generate
        for (genvar gi = 0; gi < LV; gi++) begin : g_level
            if (gi != MID) begin : g_direct
                assign lvin_p[gi] = lv_p[gi];
                assign lvin_g[gi] = lv_g[gi];
            end
            ks_prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << gi)
            ) u_level (
                .p_i (lvin_p[gi]),
                .g_i (lvin_g[gi]),
                .p_o (lv_p[gi+1]),
                .g_o (lv_g[gi+1])
            );
        end

        if (MID_REG != 0) begin : g_mid
            logic             mid_valid_q;
            logic [WIDTH-1:0] mid_p_q;
            logic [WIDTH-1:0] mid_g_q;
            logic [WIDTH-1:0] mid_p0_q;
            logic             mid_cin_q;
`ifdef KS_SUB_FLAGS_EN
            logic             mid_amsb_q;
            logic             mid_bmsb_q;
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mid_valid_q <= 1'b0;
                    mid_p_q     <= '0;
                    mid_g_q     <= '0;
                    mid_p0_q    <= '0;
                    mid_cin_q   <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
                    mid_amsb_q  <= 1'b0;
                    mid_bmsb_q  <= 1'b0;
`endif
                end else if (adv_fin) begin
                    mid_valid_q <= s0_valid_q;
                    if (s0_valid_q) begin
                        mid_p_q   <= lv_p[MID];
                        mid_g_q   <= lv_g[MID];
                        mid_p0_q  <= s0_p_q;
                        mid_cin_q <= s0_cin_q;
`ifdef KS_SUB_FLAGS_EN
                        mid_amsb_q <= s0_amsb_q;
                        mid_bmsb_q <= s0_bmsb_q;
`endif
                    end
                end
            end
            assign adv_fin     = ~mid_valid_q | adv_out;
            assign lvin_p[MID] = mid_p_q;
            assign lvin_g[MID] = mid_g_q;
            assign fin_valid   = mid_valid_q;
            assign fin_p0      = mid_p0_q;
            assign fin_cin     = mid_cin_q;
`ifdef KS_SUB_FLAGS_EN
            assign fin_amsb    = mid_amsb_q;
            assign fin_bmsb    = mid_bmsb_q;
`endif
        end else begin : g_nomid
            assign adv_fin     = adv_out;
            assign lvin_p[MID] = lv_p[MID];
            assign lvin_g[MID] = lv_g[MID];
            assign fin_valid   = s0_valid_q;
            assign fin_p0      = s0_p_q;
            assign fin_cin     = s0_cin_q;
`ifdef KS_SUB_FLAGS_EN
            assign fin_amsb    = s0_amsb_q;
            assign fin_bmsb    = s0_bmsb_q;
`endif
        end
    endgenerate

    assign carry    = lv_g[LV];
    assign diff_d   = fin_p0 ^ {carry[WIDTH-2:0], fin_cin};
    assign borrow_d = ~carry[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else if (adv_out) begin
            out_valid_q <= fin_valid;
            if (fin_valid) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
`ifdef KS_SUB_FLAGS_EN
                ovf_q    <= (fin_amsb ^ fin_bmsb) & (fin_amsb ^ diff_d[WIDTH-1]);
                zero_q   <= (diff_d == '0);
                neg_q    <= diff_d[WIDTH-1];
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef KS_SUB_FLAGS_EN
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_ks_pipe_sub.sv
// Scoreboard bench for ks_pipe_sub (WIDTH=16, MID_REG=1); flags checked when KS_SUB_FLAGS_EN is defined.
module tb_ks_pipe_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        borrow;
`ifdef KS_SUB_FLAGS_EN
    logic        ovf;
    logic        zero;
    logic        neg;
`endif

    always #5 clk = ~clk;

    ks_pipe_sub #(.WIDTH(16), .MID_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef KS_SUB_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
`endif
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        br;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;

    // Reference: plain unsigned and signed arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        exp_t        e;
        logic [16:0] full;
        int          s;
        full = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        s    = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.a  = x;
        e.b  = y;
        e.bi = bi;
        e.d  = full[15:0];
        e.br = full[16];
        e.ov = (s > 32767) || (s < -32768);
        e.z  = (full[15:0] == 16'd0);
        e.n  = full[15];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic bi, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        bin       = bi;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) sb_q.push_back(model(x, y, bi));
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 50;
        while (!acc && budget > 0) begin
            cycle(1'b1, x, y, bi, 1'b1, acc);
            budget--;
        end
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        logic acc;
        int   budget;
        budget = 200;
        while (sb_q.size() > 0 && budget > 0) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
            budget--;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin
        exp_t        e;
        logic        stall_prev;
        logic [15:0] d_prev;
        logic        b_prev;
        stall_prev = 1'b0;
        d_prev     = '0;
        b_prev     = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_result", 32'({borrow, diff}), 32'({b_prev, d_prev}));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out: got diff %h with empty scoreboard, required none", diff);
                    end else begin
                        e = sb_q.pop_front();
                        n_pop++;
                        check("diff", 32'(diff), 32'(e.d));
                        check("borrow", 32'(borrow), 32'(e.br));
`ifdef KS_SUB_FLAGS_EN
                        check("flags", 32'({ovf, zero, neg}), 32'({e.ov, e.z, e.n}));
`endif
                        $display("result a=%h b=%h bin=%b -> diff=%h borrow=%b (exp %h/%b)",
                                 e.a, e.b, e.bi, diff, borrow, e.d, e.br);
                    end
                end
                stall_prev = out_valid && !out_ready;
                d_prev     = diff;
                b_prev     = borrow;
            end
        end
    end

    initial begin
        logic        acc;
        int          cnt;
        int          idx;
        int          drops;
        int          p0;
        logic        seen;
        logic        pv;
        logic [15:0] pa;
        logic [15:0] pb;
        logic        pbi;
        logic        ordy;
        logic [15:0] corner [4];

        corner[0] = 16'h0000;
        corner[1] = 16'hFFFF;
        corner[2] = 16'h8000;
        corner[3] = 16'h7FFF;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic op and latency: out_valid exactly 3 cycles after acceptance.
        cycle(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, acc);
        check("t1_accept", 32'(acc), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
            check("t1_latency", 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
        end

        // Wrap-around and borrow-in.
        send(16'h0000, 16'h0001, 1'b0);
        send(16'h8000, 16'h0000, 1'b1);
        send(16'h1234, 16'h1234, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        // Back-pressure: six stalled cycles, only three ops fit.
        cnt = 0;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            cycle(idx <= 5, 16'(idx * 7), 16'(idx), 1'b0, 1'b0, acc);
            if (acc) begin
                cnt++;
                idx++;
            end
        end
        check("t3_accepts", 32'(cnt), 32'd3);
        check("t3_in_ready_low", 32'(in_ready), 32'd0);
        cnt = 0;
        while (idx <= 5 && cnt < 50) begin
            cycle(1'b1, 16'(idx * 7), 16'(idx), 1'b0, 1'b1, acc);
            if (acc) idx++;
            cnt++;
        end
        check("t3_all_sent", 32'(idx), 32'd6);
        drain();

        // Full throughput.
        drops = 0;
        p0    = n_pop;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc);
            if (!acc) drops++;
        end
        check("t4_in_ready_drops", 32'(drops), 32'd0);
        drain();
        check("t4_results", 32'(n_pop - p0), 32'd100);

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(100 + i), 16'(i), 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_diff", 32'(diff), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
            if (out_valid) seen = 1'b1;
        end
        check("t5_no_stale", 32'(seen), 32'd0);
        cycle(1'b1, 16'h0100, 16'h0001, 1'b1, 1'b1, acc);
        check("t5_accept", 32'(acc), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
            check("t5_latency", 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
        end

        // Random traffic with random back-pressure and held operands.
        pv  = 1'b0;
        pa  = '0;
        pb  = '0;
        pbi = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
                pv  = 1'b1;
                pa  = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
                pb  = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
                pbi = 1'($urandom_range(0, 1));
            end
            ordy = ($urandom_range(0, 3) != 0);
            cycle(pv, pa, pb, pbi, ordy, acc);
            if (acc) pv = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
